// File: rtl/bit_packer.sv
// Serial-to-parallel packer: accepts a 1-bit stream LSB-first into WIDTH-bit words with flush of partial words.
// Optional BIT_PACKER_PARITY_EN adds a registered io_out_parity output (XOR of the held word).
module bit_packer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  input  logic             io_in_bits,
  output logic             io_in_ready,
  input  logic             io_flush,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
`ifdef BIT_PACKER_PARITY_EN
  output logic             io_out_parity,
`endif
  output logic [LW-1:0]    io_out_len
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bits_q, out_bits_d;
  logic [LW-1:0]    out_len_q, out_len_d;
  logic             flush_pend_q, flush_pend_d;
`ifdef BIT_PACKER_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic             drain_ok;
  logic             in_ready;
  logic             accept;
  logic             complete;
  logic             flush_req;
  logic             do_flush;
  logic             load;
  logic [WIDTH-1:0] sh_acc;
  logic [LW-1:0]    cnt_acc;

  // sh_acc/cnt_acc already include this cycle's accepted bit, so flush and complete share them.
  always_comb begin
    drain_ok     = !out_valid_q || io_out_ready;
    in_ready     = (cnt_q != CNT_LAST) || drain_ok;
    accept       = io_in_valid && in_ready;
    complete     = accept && (cnt_q == CNT_LAST);
    flush_req    = io_flush || flush_pend_q;

    sh_acc       = sh_q;
    if (accept) begin
      sh_acc[cnt_q] = io_in_bits;
    end
    cnt_acc      = LW'(cnt_q) + LW'(accept);
    do_flush     = flush_req && drain_ok && (cnt_acc != '0) && !complete;
    load         = complete || do_flush;

    cnt_d        = accept ? CW'(cnt_acc) : cnt_q;
    sh_d         = sh_acc;
    out_valid_d  = out_valid_q;
    out_bits_d   = out_bits_q;
    out_len_d    = out_len_q;
    flush_pend_d = flush_pend_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_bits_d  = sh_acc;
      out_len_d   = complete ? LW'(WIDTH) : cnt_acc;
      cnt_d       = '0;
      sh_d        = '0;
    end else if (out_valid_q && io_out_ready) begin
      out_valid_d = 1'b0;
    end

    // A request that cannot be served now is remembered; an empty one is dropped.
    if (flush_req) begin
      flush_pend_d = complete || !drain_ok;
    end

`ifdef BIT_PACKER_PARITY_EN
    out_parity_d = ^out_bits_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      sh_q         <= '0;
      out_valid_q  <= 1'b0;
      out_bits_q   <= '0;
      out_len_q    <= '0;
      flush_pend_q <= 1'b0;
`ifdef BIT_PACKER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      out_valid_q  <= out_valid_d;
      out_bits_q   <= out_bits_d;
      out_len_q    <= out_len_d;
      flush_pend_q <= flush_pend_d;
`ifdef BIT_PACKER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign io_in_ready  = in_ready;
  assign io_out_valid = out_valid_q;
  assign io_out_bits  = out_bits_q;
  assign io_out_len   = out_len_q;
`ifdef BIT_PACKER_PARITY_EN
  assign io_out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: directed scenarios plus random traffic against a queue-based model.
module tb_bit_packer;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          io_in_valid, io_in_bits, io_in_ready, io_flush;
  logic          io_out_valid, io_out_ready;
  logic [W-1:0]  io_out_bits;
  logic [LW-1:0] io_out_len;
`ifdef BIT_PACKER_PARITY_EN
  logic          io_out_parity;
`endif

  bit_packer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_in_ready  (io_in_ready),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
`ifdef BIT_PACKER_PARITY_EN
    .io_out_parity(io_out_parity),
`endif
    .io_out_len   (io_out_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: bits collected so far, plus the holding register contents.
  bit          m_part[$];
  bit          m_vld;
  logic [31:0] m_bits;
  int          m_len;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (m_part.size() < W - 1) || !m_vld || io_out_ready;
  endfunction

  function automatic logic [31:0] pack_part();
    logic [31:0] w = '0;
    foreach (m_part[k]) w[k] = m_part[k];
    return w;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_vld = 0; m_bits = '0; m_len = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit f, input bit r, input bit rdy);
    bit drain, acc, comp, freq;
    drain = !m_vld || r;
    acc   = v && rdy;
    comp  = acc && (m_part.size() == W - 1);
    freq  = f || m_pend;
    if (acc) m_part.push_back(b);
    if (comp || (freq && drain && m_part.size() > 0)) begin
      m_bits = pack_part();
      m_len  = m_part.size();
      m_vld  = 1;
      m_part.delete();
    end else if (m_vld && r) begin
      m_vld = 0;
    end
    if (freq) m_pend = comp || !drain;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(io_out_valid), 32'(m_vld));
    check("out_bits", 32'(io_out_bits), m_bits);
    check("out_len", 32'(io_out_len), 32'(m_len));
`ifdef BIT_PACKER_PARITY_EN
    check("out_parity", 32'(io_out_parity), 32'(^m_bits));
`endif
  endtask

  // One clock: drive, check ready, clock edge, advance model, check registered outputs.
  task automatic cycle(input bit v, input bit b, input bit f, input bit r);
    bit rdy;
    io_in_valid = v; io_in_bits = b; io_flush = f; io_out_ready = r;
    #1;
    rdy = model_ready();
    check("in_ready", 32'(io_in_ready), 32'(rdy));
    @(posedge clk);
    model_step(v, b, f, r, rdy);
    #1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] pat, input bit r);
    for (int i = 0; i < 8; i++) cycle(1'b1, pat[i], 1'b0, r);
  endtask

  initial begin
    reset = 1'b1; io_in_valid = 0; io_in_bits = 0; io_flush = 0; io_out_ready = 0;
    model_reset();
    #12;
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_bits", 32'(io_out_bits), 32'd0);
    check("rst_len", 32'(io_out_len), 32'd0);
    check("rst_ready", 32'(io_in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic packing: 1,0,1,0,0,1,0,1 -> 0xA5
    send_byte(8'hA5, 1'b1);
    check("basic_valid", 32'(io_out_valid), 32'd1);
    check("basic_bits", 32'(io_out_bits), 32'hA5);
    check("basic_len", 32'(io_out_len), 32'd8);
`ifdef BIT_PACKER_PARITY_EN
    check("par_a5", 32'(io_out_parity), 32'd0);
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_one_cycle", 32'(io_out_valid), 32'd0);

    // Backpressure: 15 ones accepted, 16th stalls until ready rises
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    io_out_ready = 1'b0; #1;
    check("bp_stall_ready", 32'(io_in_ready), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("bp_second_valid", 32'(io_out_valid), 32'd1);
    check("bp_second_bits", 32'(io_out_bits), 32'hFF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush of 1,1,0 -> 0x03 len 3, next word starts at bit 0
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_bits", 32'(io_out_bits), 32'h03);
    check("flush_len", 32'(io_out_len), 32'd3);
    send_byte(8'h3C, 1'b1);
    check("after_flush_bits", 32'(io_out_bits), 32'h3C);

    // Flush together with the 4th bit: 1,0,0 + (1,flush) -> 0x09 len 4
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("flush4_bits", 32'(io_out_bits), 32'h09);
    check("flush4_len", 32'(io_out_len), 32'd4);

    // Empty flush is discarded
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("empty_flush", 32'(io_out_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("empty_flush_later", 32'(io_out_valid), 32'd0);

    // Flush pending behind a held word
    send_byte(8'h5A, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_held_bits", 32'(io_out_bits), 32'h5A);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pend_flush_valid", 32'(io_out_valid), 32'd1);
    check("pend_flush_bits", 32'(io_out_bits), 32'h01);
    check("pend_flush_len", 32'(io_out_len), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset with a held word and cnt=5
    send_byte(8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    io_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(io_out_valid), 32'd0);
    check("arst_bits", 32'(io_out_bits), 32'd0);
    check("arst_len", 32'(io_out_len), 32'd0);
    model_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    check_outputs();
    send_byte(8'h96, 1'b1);
    check("post_rst_bits", 32'(io_out_bits), 32'h96);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BIT_PACKER_PARITY_EN
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("par_07_bits", 32'(io_out_bits), 32'h07);
    check("par_07", 32'(io_out_parity), 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) < 6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
